// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM, with lock support for read-modify-write.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin conflict resolution; the default build uses fixed priority to A.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_lock,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic prefer_a;
  logic a_gnt_c, b_gnt_c;
  logic a_acc, b_acc;

  always_comb begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    prefer_a = last_b_q;
`else
    // The pointer is tracked in both builds; fixed priority simply ignores it.
    prefer_a = last_b_q | 1'b1;
`endif
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          a_gnt_c = prefer_a;
          b_gnt_c = !prefer_a;
        end else begin
          a_gnt_c = a_req;
          b_gnt_c = b_req;
        end
      end
      OWN_A:   a_gnt_c = a_req;
      OWN_B:   b_gnt_c = b_req;
      default: ;
    endcase
  end

  // Grants are combinational, so they are masked directly while reset is held.
  assign a_gnt = a_gnt_c & rst_n;
  assign b_gnt = b_gnt_c & rst_n;
  assign a_acc = a_req & a_gnt;
  assign b_acc = b_req & b_gnt;

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_a_d      = 1'b0;
    rd_b_d      = 1'b0;
    if (a_acc) begin
      state_d     = a_lock ? OWN_A : IDLE;
      last_b_d    = 1'b0;
      mem_addr_d  = a_addr;
      mem_wdata_d = a_wdata;
      mem_we_d    = a_we;
      rd_a_d      = !a_we;
    end else if (b_acc) begin
      state_d     = b_lock ? OWN_B : IDLE;
      last_b_d    = 1'b1;
      mem_addr_d  = b_addr;
      mem_wdata_d = b_wdata;
      mem_we_d    = b_we;
      rd_b_d      = !b_we;
    end else if (state_q != OWN_A && state_q != OWN_B) begin
      state_d = IDLE;
    end
  end

  // RAM data for a read issued at the previous edge is valid now; capture it at this edge.
  always_comb begin
    a_rvalid_d = rd_a_q;
    b_rvalid_d = rd_b_q;
    a_rdata_d  = rd_a_q ? mem_rdata : a_rdata_q;
    b_rdata_d  = rd_b_q ? mem_rdata : b_rdata_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_a_q      <= 1'b0;
      rd_b_q      <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a read-return scoreboard and per-cycle memory-port model.
// Expected conflict grants follow MEM_ARBITER_ROUND_ROBIN_EN exactly as the design build does.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_lock = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_lock = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM: the arbiter's registered address is the RAM address register, so read data follows it.
  logic [DW-1:0] ram    [0:65535];
  logic [DW-1:0] shadow [0:65535];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  function automatic logic [7:0] pat(input int i);
    return i[7:0] ^ i[15:8] ^ 8'h3C;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_t;

  rd_t           qa[$];
  rd_t           qb[$];
  rd_t           e;
  int            cyc = 0;
  logic          exp_we = 1'b0;
  logic          exp_acc = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  // Monitor: memory port, grant legality and read returns against expectations built at accept time.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      check("mem_we", mem_we, exp_we);
      if (exp_acc) check("mem_addr", mem_addr, exp_addr);
      if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      check("gnt_onehot", a_gnt & b_gnt, 0);
      check("gnt_without_req", (a_gnt & ~a_req) | (b_gnt & ~b_req), 0);
      if (a_rvalid) begin
        if (qa.size() == 0) check("a_rvalid_unexpected", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_rdata_sb", a_rdata, e.data);
          check("a_rvalid_cycle", cyc, e.due);
        end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
        check("a_rvalid_missing", 0, 1);
        void'(qa.pop_front());
      end
      if (b_rvalid) begin
        if (qb.size() == 0) check("b_rvalid_unexpected", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_rdata_sb", b_rdata, e.data);
          check("b_rvalid_cycle", cyc, e.due);
        end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
        check("b_rvalid_missing", 0, 1);
        void'(qb.pop_front());
      end
      exp_acc = 1'b0;
      exp_we  = 1'b0;
      if (a_req && a_gnt) begin
        exp_acc = 1'b1; exp_addr = a_addr; exp_we = a_we; exp_wdata = a_wdata;
        if (a_we) shadow[a_addr] = a_wdata;
        else qa.push_back('{shadow[a_addr], cyc + 2});
      end else if (b_req && b_gnt) begin
        exp_acc = 1'b1; exp_addr = b_addr; exp_we = b_we; exp_wdata = b_wdata;
        if (b_we) shadow[b_addr] = b_wdata;
        else qb.push_back('{shadow[b_addr], cyc + 2});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic lock, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    a_req = req; a_lock = lock; a_we = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic lock, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    b_req = req; b_lock = lock; b_we = we; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    exp_we  = 1'b0;
    exp_acc = 1'b0;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_a_gnt"}, a_gnt, 0);
    check({p, "_b_gnt"}, b_gnt, 0);
    check({p, "_mem_we"}, mem_we, 0);
    check({p, "_mem_addr"}, mem_addr, 0);
    check({p, "_mem_wdata"}, mem_wdata, 0);
    check({p, "_a_rvalid"}, a_rvalid, 0);
    check({p, "_b_rvalid"}, b_rvalid, 0);
    check({p, "_a_rdata"}, a_rdata, 0);
    check({p, "_b_rdata"}, b_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_a;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = pat(i);
      shadow[i] = pat(i);
    end
    ram[16'h0123]    = 8'h5A;
    shadow[16'h0123] = 8'h5A;

    // Reset state, with both requests raised while reset is held.
    enter_reset();
    repeat (2) @(negedge clk);
    drive_a(1, 0, 0, 16'h0123, 0);
    drive_b(1, 0, 0, 16'h0200, 0);
    @(negedge clk);
    check_reset_outputs("rst0");
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // A reads 0x0123 alone.
    step();
    drive_a(1, 0, 0, 16'h0123, 0);
    @(negedge clk); check("t1_a_gnt", a_gnt, 1);
    step(); drive_a(0, 0, 0, 0, 0);
    @(negedge clk); check("t1_mem_addr", mem_addr, 16'h0123); check("t1_rvalid_c1", a_rvalid, 0);
    step();
    @(negedge clk); check("t1_rvalid_c2", a_rvalid, 1); check("t1_rdata_c2", a_rdata, 8'h5A);
    step();
    @(negedge clk); check("t1_rvalid_c3", a_rvalid, 0);

    // B writes 0x77 to 0x0D00.
    step();
    drive_b(1, 0, 1, 16'h0D00, 8'h77);
    @(negedge clk); check("t2_b_gnt", b_gnt, 1);
    step(); drive_b(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 16'h0D00);
    check("t2_mem_wdata", mem_wdata, 8'h77);
    step();
    @(negedge clk); check("t2_mem_we_off", mem_we, 0); check("t2_no_rvalid1", b_rvalid, 0);
    step();
    @(negedge clk); check("t2_no_rvalid2", b_rvalid, 0);

    // Continuous conflict for six cycles.
    step();
    drive_a(1, 0, 0, 16'h0200, 0);
    drive_b(1, 0, 0, 16'h0300, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      check("t3_a_gnt", a_gnt, exp_a);
      check("t3_b_gnt", b_gnt, !exp_a);
      step();
    end
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    repeat (3) step();

    // Locked read-modify-write by A while B keeps requesting.
    drive_a(1, 1, 0, 16'h0F10, 0);
    drive_b(1, 0, 0, 16'h0100, 0);
    @(negedge clk); check("t4_lock_rd_a", a_gnt, 1); check("t4_lock_rd_b", b_gnt, 0);
    step(); drive_a(0, 0, 0, 0, 0);
    @(negedge clk); check("t4_stall_a", a_gnt, 0); check("t4_stall_b", b_gnt, 0);
    step(); drive_a(1, 0, 1, 16'h0F10, 8'hA5);
    @(negedge clk); check("t4_wr_a", a_gnt, 1); check("t4_wr_b", b_gnt, 0);
    step(); drive_a(0, 0, 0, 0, 0);
    @(negedge clk); check("t4_release_b", b_gnt, 1);
    step(); drive_b(0, 0, 0, 0, 0);
    repeat (3) step();

    // Reset one cycle after a locked A read is accepted.
    drive_a(1, 1, 0, 16'h0040, 0);
    @(negedge clk); check("t5_a_gnt", a_gnt, 1);
    step();
    drive_a(0, 0, 0, 0, 0);
    drive_b(1, 0, 0, 16'h0050, 0);
    enter_reset();
    @(negedge clk);
    check_reset_outputs("t5_rst");
    step();
    rst_n = 1'b1;
    @(negedge clk); check("t5_lock_dropped_b_gnt", b_gnt, 1); check("t5_no_rvalid0", a_rvalid, 0);
    step(); drive_b(0, 0, 0, 0, 0);
    @(negedge clk); check("t5_no_rvalid1", a_rvalid, 0);
    step();
    @(negedge clk); check("t5_no_rvalid2", a_rvalid, 0);
    repeat (2) step();

    // Back-to-back A reads of 0x0010..0x0012.
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive_a(1, 0, 0, 16'h0010 + 16'(k), 0);
      else drive_a(0, 0, 0, 0, 0);
      @(negedge clk);
      if (k < 3) check("t6_a_gnt", a_gnt, 1);
      if (k >= 2) begin
        check("t6_rvalid", a_rvalid, 1);
        check("t6_rdata", a_rdata, pat(16 + k - 2));
      end
      step();
    end
    @(negedge clk); check("t6_rvalid_end", a_rvalid, 0);

    repeat (4) step();
    check("sb_drain", qa.size() + qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16, as the memory address width.
REQ-002 The block SHALL take parameter DATA_W, default 8, as the memory data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports a_req / b_req, input, 1 bit: access request from requester A (CPU core) / B (display/IO scanner).
REQ-006 The block SHALL have ports a_lock / b_lock, input, 1 bit: the requester keeps bus ownership after its current access (read-modify-write).
REQ-007 The block SHALL have ports a_we / b_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have ports a_addr / b_addr, input, ADDR_W bits, and a_wdata / b_wdata, input, DATA_W bits.
REQ-009 The block SHALL have ports a_gnt / b_gnt, output, 1 bit: combinational acceptance of the request in the current cycle.
REQ-010 The block SHALL have ports a_rvalid / b_rvalid, output, 1 bit, and a_rdata / b_rdata, output, DATA_W bits: the read-data return.
REQ-011 The block SHALL have ports mem_addr, output, ADDR_W bits; mem_we, output, 1 bit; mem_wdata, output, DATA_W bits; mem_rdata, input, DATA_W bits: a synchronous RAM with 1-cycle read latency.

Function
REQ-012 The handshake SHALL be valid/ready: a request is accepted on a rising edge where req and gnt are both 1; the requester holds addr/we/wdata/lock stable until then.
REQ-013 The gnt outputs SHALL be one-hot or zero, and no gnt SHALL be asserted to a requester whose req is 0.
REQ-014 On acceptance, mem_addr, mem_we and mem_wdata SHALL be registered from the accepted requester and drive the RAM for exactly one cycle.
REQ-015 mem_we SHALL be 0 in every cycle without an accepted write; mem_addr and mem_wdata SHALL hold their last values.
REQ-016 For an accepted read at edge E0, the arbiter SHALL sample RAM data at E1 and assert the requester's rvalid for exactly one cycle after E1, with rdata equal to mem_rdata.
REQ-017 Writes SHALL produce no rvalid; back-to-back accepts SHALL sustain one access per cycle with pipelined rvalid returns in issue order.
REQ-018 The state machine SHALL have states IDLE, OWN_A and OWN_B.
REQ-019 In IDLE: a single requester SHALL be granted; if both request, the arbitration policy (REQ-026/027) SHALL choose.
REQ-020 When an accept has lock=1, the next state SHALL be OWN_x for that requester; when lock=0, the next state SHALL be IDLE.
REQ-021 In OWN_x, only requester x SHALL be granted, even if the other requests; the block SHALL stay in OWN_x until x is accepted with lock=0.
REQ-022 In OWN_x, if x deasserts req, the block SHALL remain in OWN_x (no timeout) and the other requester SHALL stall.
REQ-023 The block SHALL keep a last-granted pointer updated on every accept.

Reset
REQ-024 While rst_n is 0, the block SHALL hold: state IDLE; mem_we 0; mem_addr 0; mem_wdata 0; a_gnt, b_gnt 0; a_rvalid, b_rvalid 0; a_rdata, b_rdata 0; last-granted = B.
REQ-025 Reset asserted mid-operation SHALL discard pending read returns and any held lock; no rvalid SHALL appear after reset release for a pre-reset access.

Configuration
REQ-026 With macro MEM_ARBITER_ROUND_ROBIN_EN defined, an IDLE-state conflict SHALL be granted to the requester that was not last granted.
REQ-027 Without MEM_ARBITER_ROUND_ROBIN_EN, an IDLE-state conflict SHALL always be granted to A (fixed priority); lock behaviour SHALL be identical in both builds.

Verification
REQ-028 The bench SHALL cover: A reads 0x0123 alone, RAM[0x0123]=0x5A -> a_gnt in cycle 0, mem_addr=0x0123 in cycle 1, a_rvalid=1 with a_rdata=0x5A in cycle 2 only.
REQ-029 The bench SHALL cover: B writes 0x77 to 0x0D00 -> mem_we=1 for exactly one cycle with mem_addr=0x0D00, mem_wdata=0x77; no b_rvalid.
REQ-030 The bench SHALL cover: A and B request continuously for 6 cycles -> round-robin grants alternate A,B,A,B,A,B; fixed-priority grants A six times with b_gnt=0.
REQ-031 The bench SHALL cover: A reads 0x0F10 with lock=1, then writes 0x0F10 with lock=0, while B requests throughout -> b_gnt=0 until the A write is accepted, then b_gnt=1 on the next cycle.
REQ-032 The bench SHALL cover: rst_n pulsed low one cycle after an A read accept -> a_rvalid stays 0 and all outputs take REQ-024 values.
REQ-033 The bench SHALL cover: A reads 0x0010, 0x0011, 0x0012 back-to-back -> three consecutive a_rvalid cycles returning the three RAM bytes in order.
